// File: rtl/design_1_seq_mul.sv
// Multi-cycle shift-add multiplier: one partial product per clock, valid/ready on both sides.
// Optional running accumulation of products when SEQ_MUL_ACCUM_EN is defined (adds port acc_en).
module design_1_seq_mul #(
  parameter  int DataWidth = 16,
  localparam int CntWidth  = $clog2(DataWidth) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DataWidth-1:0]   a,
  input  logic [DataWidth-1:0]   b,
  input  logic                   signed_mode,
`ifdef SEQ_MUL_ACCUM_EN
  input  logic                   acc_en,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*DataWidth-1:0] p
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // BUSY  | one partial product per cycle, then one cycle to finalise p
  // DONE  | product held on p until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [DataWidth-1:0]   mcand;
  logic [DataWidth-1:0]   mplier;
  logic [2*DataWidth-1:0] accum;
  logic [CntWidth-1:0]    cnt;
  logic                   negQ;

  logic [DataWidth-1:0]   magA;
  logic [DataWidth-1:0]   magB;
  logic [DataWidth:0]     sum;
  logic [2*DataWidth-1:0] product;
  logic [2*DataWidth-1:0] finalVal;

`ifdef SEQ_MUL_ACCUM_EN
  logic                   accEnQ;
  logic [2*DataWidth-1:0] accReg;
`endif

  // -2^(DataWidth-1) negates to itself, which is the correct unsigned magnitude
  always_comb begin
    magA = (signed_mode && a[DataWidth-1]) ? (~a + DataWidth'(1)) : a;
    magB = (signed_mode && b[DataWidth-1]) ? (~b + DataWidth'(1)) : b;
    sum  = {1'b0, accum[2*DataWidth-1:DataWidth]}
         + (mplier[0] ? {1'b0, mcand} : {(DataWidth+1){1'b0}});
    product = negQ ? (~accum + (2*DataWidth)'(1)) : accum;
`ifdef SEQ_MUL_ACCUM_EN
    finalVal = accEnQ ? (accReg + product) : product;
`else
    finalVal = product;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      mcand     <= '0;
      mplier    <= '0;
      accum     <= '0;
      cnt       <= '0;
      negQ      <= 1'b0;
`ifdef SEQ_MUL_ACCUM_EN
      accEnQ    <= 1'b0;
      accReg    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= magA;
            mplier   <= magB;
            negQ     <= signed_mode & (a[DataWidth-1] ^ b[DataWidth-1]);
            accum    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef SEQ_MUL_ACCUM_EN
            accEnQ   <= acc_en;
`endif
          end
        end
        BUSY: begin
          if (cnt == CntWidth'(DataWidth)) begin
            p         <= finalVal;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SEQ_MUL_ACCUM_EN
            accReg    <= finalVal;
`endif
          end else begin
            accum  <= {sum, accum[DataWidth-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + CntWidth'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
